// File: rtl/data_cache_controller_pkg.sv
// Shared definitions for the data cache controller: geometry, FSM state
// encoding and small helpers used by the controller and its storage.
package data_cache_controller_pkg;

    localparam int CACHE_SETS      = 64;
    localparam int CACHE_TAG_LEN   = 10;
    localparam int CACHE_INDEX_LEN = $clog2(CACHE_SETS);
    localparam int CACHE_WORD_LEN  = 32;

    typedef enum logic [1:0] {
        CACHE_IDLE  = 2'd0,
        CACHE_FILL0 = 2'd1,
        CACHE_FILL1 = 2'd2,
        CACHE_WRITE = 2'd3
    } cache_state_t;

    // The LRU bit names the way to evict next, so touching a way points it
    // at the other one.
    function automatic logic other_way(input logic way);
        return ~way;
    endfunction

endpackage

// File: rtl/data_cache_controller_cache_memory.sv
// Storage for the 2-way cache: valid, tag, 2-word data lines and one LRU
// bit per set.
//   rd_index              combinational read index (both ways in parallel)
//   rd_valid/tag/data/lru per-way contents of the indexed set
//   fill_*                whole-line write of one way (sets valid)
//   upd_*                 single-word write into one way
//   lru_*                 LRU bit update
//   wr_index              set addressed by all writes
// Valid and LRU clear asynchronously on rst_n low; tags and data are
// never reset because they are qualified by valid.
module cache_memory
    import data_cache_controller_pkg::*;
#(
    parameter int SETS      = CACHE_SETS,
    parameter int TAG_LEN   = CACHE_TAG_LEN,
    parameter int WORD_LEN  = CACHE_WORD_LEN,
    parameter int INDEX_LEN = $clog2(SETS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [INDEX_LEN-1:0]             rd_index,
    output logic [1:0]                       rd_valid,
    output logic [1:0][TAG_LEN-1:0]          rd_tag,
    output logic [1:0][1:0][WORD_LEN-1:0]    rd_data,
    output logic                             rd_lru,
    input  logic [INDEX_LEN-1:0]             wr_index,
    input  logic                             fill_en,
    input  logic                             fill_way,
    input  logic [TAG_LEN-1:0]               fill_tag,
    input  logic [1:0][WORD_LEN-1:0]         fill_data,
    input  logic                             upd_en,
    input  logic                             upd_way,
    input  logic                             upd_offset,
    input  logic [WORD_LEN-1:0]              upd_data,
    input  logic                             lru_en,
    input  logic                             lru_value
);

    logic [1:0]          valid_r [SETS];
    logic [SETS-1:0]     lru_r;
    logic [TAG_LEN-1:0]  tag_r   [2][SETS];
    logic [WORD_LEN-1:0] data_r  [2][SETS][2];

    // Valid and LRU state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= 2'b00;
            end
            lru_r <= {SETS{1'b0}};
        end else begin
            if (fill_en) begin
                valid_r[wr_index][fill_way] <= 1'b1;
            end
            if (lru_en) begin
                lru_r[wr_index] <= lru_value;
            end
        end
    end

    // Tag and data arrays: line fill or single-word update.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_r[fill_way][wr_index]     <= fill_tag;
            data_r[fill_way][wr_index][0] <= fill_data[0];
            data_r[fill_way][wr_index][1] <= fill_data[1];
        end else if (upd_en) begin
            data_r[upd_way][wr_index][upd_offset] <= upd_data;
        end
    end

    // Combinational read of both ways of the indexed set.
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            rd_valid[w]   = valid_r[rd_index][w];
            rd_tag[w]     = tag_r[w][rd_index];
            rd_data[w][0] = data_r[w][rd_index][0];
            rd_data[w][1] = data_r[w][rd_index][1];
        end
        rd_lru = lru_r[rd_index];
    end

endmodule

// File: rtl/data_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller.
//   clk, rst               clock; asynchronous active-low reset
//   read_enable/write_enable/address/write_data   MEM-stage request
//   read_data, ready       load result and pipeline freeze (0 = stall)
//   sram_*                 handshake to the SRAM controller
// Read hits complete combinationally in the request cycle; misses fill a
// 2-word line with two back-to-back SRAM reads; all writes go to SRAM and
// update the cached word only on a hit.
module data_cache_controller
    import data_cache_controller_pkg::*;
#(
    parameter int SETS     = CACHE_SETS,
    parameter int TAG_LEN  = CACHE_TAG_LEN,
    parameter int WORD_LEN = CACHE_WORD_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_enable,
    input  logic                write_enable,
    input  logic [31:0]         address,
    input  logic [WORD_LEN-1:0] write_data,
    output logic [WORD_LEN-1:0] read_data,
    output logic                ready,
    output logic                sram_read_enable,
    output logic                sram_write_enable,
    output logic [31:0]         sram_address,
    output logic [WORD_LEN-1:0] sram_write_data,
    input  logic [WORD_LEN-1:0] sram_read_data,
    input  logic                sram_ready
);

    localparam int INDEX_LEN = $clog2(SETS);

    cache_state_t                  state_r;
    logic                          victim_r;
    logic [WORD_LEN-1:0]           word0_r;
    logic                          sram_read_enable_r;
    logic                          sram_write_enable_r;
    logic [31:0]                   sram_address_r;
    logic [WORD_LEN-1:0]           sram_write_data_r;

    logic [INDEX_LEN-1:0]          index_s;
    logic [TAG_LEN-1:0]            tag_s;
    logic                          offset_s;
    logic [1:0]                    rd_valid_s;
    logic [1:0][TAG_LEN-1:0]       rd_tag_s;
    logic [1:0][1:0][WORD_LEN-1:0] rd_data_s;
    logic                          rd_lru_s;
    logic [1:0]                    hit_way_s;
    logic                          hit_s;
    logic                          hit_idx_s;
    logic                          victim_s;
    logic                          ready_s;
    logic [WORD_LEN-1:0]           read_data_s;
    logic                          fill_en_s;
    logic                          upd_en_s;
    logic                          lru_en_s;
    logic                          lru_value_s;
    logic [1:0][WORD_LEN-1:0]      fill_data_s;
    logic                          unused_s;

    assign offset_s    = address[2];
    assign index_s     = address[3 +: INDEX_LEN];
    assign tag_s       = address[3 + INDEX_LEN +: TAG_LEN];
    assign fill_data_s = {sram_read_data, word0_r};
    assign unused_s    = ^address[1:0];

    cache_memory #(
        .SETS     (SETS),
        .TAG_LEN  (TAG_LEN),
        .WORD_LEN (WORD_LEN)
    ) u_mem (
        .clk        (clk),
        .rst_n      (rst),
        .rd_index   (index_s),
        .rd_valid   (rd_valid_s),
        .rd_tag     (rd_tag_s),
        .rd_data    (rd_data_s),
        .rd_lru     (rd_lru_s),
        .wr_index   (index_s),
        .fill_en    (fill_en_s),
        .fill_way   (victim_r),
        .fill_tag   (tag_s),
        .fill_data  (fill_data_s),
        .upd_en     (upd_en_s),
        .upd_way    (hit_idx_s),
        .upd_offset (offset_s),
        .upd_data   (write_data),
        .lru_en     (lru_en_s),
        .lru_value  (lru_value_s)
    );

    // Per-way hit detection and victim choice (invalid ways first, then LRU).
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            hit_way_s[w] = rd_valid_s[w] && (rd_tag_s[w] == tag_s);
        end
        hit_s     = |hit_way_s;
        hit_idx_s = hit_way_s[1];
        if (!rd_valid_s[0]) begin
            victim_s = 1'b0;
        end else if (!rd_valid_s[1]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = rd_lru_s;
        end
    end

    // Request completion, load data and storage write strobes per state.
    always_comb begin
        ready_s     = 1'b1;
        read_data_s = {WORD_LEN{1'b0}};
        fill_en_s   = 1'b0;
        upd_en_s    = 1'b0;
        lru_en_s    = 1'b0;
        lru_value_s = 1'b0;
        case (state_r)
            CACHE_IDLE: begin
                if (write_enable) begin
                    ready_s = 1'b0;
                end else if (read_enable) begin
                    if (hit_s) begin
                        read_data_s = rd_data_s[hit_idx_s][offset_s];
                        lru_en_s    = 1'b1;
                        lru_value_s = other_way(hit_idx_s);
                    end else begin
                        ready_s = 1'b0;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            CACHE_FILL0: begin
                ready_s = 1'b0;
            end
            CACHE_FILL1: begin
                if (sram_ready) begin
                    read_data_s = offset_s ? sram_read_data : word0_r;
                    fill_en_s   = 1'b1;
                    lru_en_s    = 1'b1;
                    lru_value_s = other_way(victim_r);
                end else begin
                    ready_s = 1'b0;
                end
            end
            CACHE_WRITE: begin
                if (sram_ready) begin
                    if (hit_s) begin
                        upd_en_s    = 1'b1;
                        lru_en_s    = 1'b1;
                        lru_value_s = other_way(hit_idx_s);
                    end else begin
                        upd_en_s = 1'b0;
                    end
                end else begin
                    ready_s = 1'b0;
                end
            end
            default: begin
                ready_s = 1'b1;
            end
        endcase
    end

    // Controller FSM with registered SRAM request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r             <= CACHE_IDLE;
            victim_r            <= 1'b0;
            word0_r             <= {WORD_LEN{1'b0}};
            sram_read_enable_r  <= 1'b0;
            sram_write_enable_r <= 1'b0;
            sram_address_r      <= 32'h0000_0000;
            sram_write_data_r   <= {WORD_LEN{1'b0}};
        end else begin
            case (state_r)
                CACHE_IDLE: begin
                    if (write_enable) begin
                        state_r             <= CACHE_WRITE;
                        sram_write_enable_r <= 1'b1;
                        sram_address_r      <= {address[31:2], 2'b00};
                        sram_write_data_r   <= write_data;
                    end else if (read_enable && !hit_s) begin
                        state_r            <= CACHE_FILL0;
                        victim_r           <= victim_s;
                        sram_read_enable_r <= 1'b1;
                        sram_address_r     <= {address[31:3], 3'b000};
                    end else begin
                        state_r <= CACHE_IDLE;
                    end
                end
                CACHE_FILL0: begin
                    // Read enable stays high so the second read follows at once.
                    if (sram_ready) begin
                        state_r        <= CACHE_FILL1;
                        word0_r        <= sram_read_data;
                        sram_address_r <= {address[31:3], 3'b100};
                    end else begin
                        state_r <= CACHE_FILL0;
                    end
                end
                CACHE_FILL1: begin
                    if (sram_ready) begin
                        state_r            <= CACHE_IDLE;
                        sram_read_enable_r <= 1'b0;
                        sram_address_r     <= 32'h0000_0000;
                    end else begin
                        state_r <= CACHE_FILL1;
                    end
                end
                CACHE_WRITE: begin
                    if (sram_ready) begin
                        state_r             <= CACHE_IDLE;
                        sram_write_enable_r <= 1'b0;
                        sram_address_r      <= 32'h0000_0000;
                        sram_write_data_r   <= {WORD_LEN{1'b0}};
                    end else begin
                        state_r <= CACHE_WRITE;
                    end
                end
                default: begin
                    state_r             <= CACHE_IDLE;
                    sram_read_enable_r  <= 1'b0;
                    sram_write_enable_r <= 1'b0;
                    sram_address_r      <= 32'h0000_0000;
                    sram_write_data_r   <= {WORD_LEN{1'b0}};
                end
            endcase
        end
    end

    // Outputs; the combinational ones are forced idle while reset is held.
    always_comb begin
        sram_read_enable  = sram_read_enable_r;
        sram_write_enable = sram_write_enable_r;
        sram_address      = sram_address_r;
        sram_write_data   = sram_write_data_r;
        if (!rst) begin
            ready     = 1'b1;
            read_data = {WORD_LEN{1'b0}};
        end else begin
            ready     = ready_s;
            read_data = read_data_s;
        end
    end

endmodule
